// File: rtl/tl_ad_buffer_pkg.sv
// Purpose: shared definitions for the TileLink A/D channel buffer.
//   - TileLink field widths that are fixed by the protocol (opcode, param, size)
//   - A and D opcode encodings used on this port
//   - default payload widths and the canonical packed beat layouts.
// The beat structs use the default payload widths. The top module packs its
// beats in the same field order, but sizes them from its own parameters.
package tl_ad_buffer_pkg;

    localparam int OPCODE_W  = 3;
    localparam int A_PARAM_W = 3;
    localparam int D_PARAM_W = 2;
    localparam int SIZE_W    = 3;

    localparam int TL_SRC_W  = 7;
    localparam int TL_ADDR_W = 31;
    localparam int TL_DATA_W = 64;

    localparam logic [OPCODE_W-1:0] A_PUT_FULL    = 3'd0;
    localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [OPCODE_W-1:0] A_GET         = 3'd4;

    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [OPCODE_W-1:0]    opcode;
        logic [A_PARAM_W-1:0]   param;
        logic [SIZE_W-1:0]      size;
        logic [TL_SRC_W-1:0]    source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_DATA_W/8-1:0] mask;
        logic [TL_DATA_W-1:0]   data;
    } a_beat_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [D_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [TL_SRC_W-1:0]  source;
        logic                 denied;
        logic                 corrupt;
        logic [TL_DATA_W-1:0] data;
    } d_beat_t;

endpackage

// File: rtl/tl_ad_channel_buffer_fifo.sv
// Purpose: generic DEPTH x WIDTH circular FIFO with a valid/ready handshake
// on both sides and an occupancy count.
// Optional feature, selected by the macro TL_AD_BUFFER_FLOW_EN: when the FIFO
// is empty, an incoming beat is presented on the output in the same cycle.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     enqueue handshake, in_data payload
//   out_valid/out_ready   dequeue handshake, out_data payload
//   count                 current occupancy, 0..DEPTH
module tl_ad_fifo
    import tl_ad_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             enq;
    logic             deq;

    assign empty    = (count == '0);
    // Ready depends only on registered occupancy, so a full FIFO never
    // accepts on the strength of a same-cycle dequeue.
    assign in_ready = (count != CNT_W'(DEPTH));

`ifdef TL_AD_BUFFER_FLOW_EN
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : storage[rd_ptr];
    // A beat that passes straight through while empty is never stored.
    assign enq       = in_valid && in_ready && !(empty && out_ready);
    assign deq       = !empty && out_ready;
`else
    assign out_valid = !empty;
    assign out_data  = storage[rd_ptr];
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (enq) begin
                storage[wr_ptr] <= in_data;
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tl_ad_channel_buffer.sv
// Purpose: registered TileLink A/D channel buffer. Two independent FIFOs cut
// the valid/ready paths between the core-side crossbar and the bridge port:
// A carries requests master->slave, D carries responses slave->master.
// Optional feature macro: TL_AD_BUFFER_FLOW_EN (same-cycle flow-through when a
// FIFO is empty); undefined gives strict one-cycle registered latency.
// Ports:
//   clock, reset                   clock and asynchronous active-high reset
//   in_a_* / out_a_*               A channel, upstream side in, downstream out
//   in_d_* / out_d_*               D channel, downstream side in, upstream out
//   a_count, d_count               FIFO occupancies
module tl_ad_channel_buffer
    import tl_ad_buffer_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int SRC_W   = 7,
    parameter int ADDR_W  = 31,
    parameter int DATA_W  = 64
) (
    input  logic                           clock,
    input  logic                           reset,

    input  logic                           in_a_valid,
    output logic                           in_a_ready,
    input  logic [OPCODE_W-1:0]            in_a_opcode,
    input  logic [A_PARAM_W-1:0]           in_a_param,
    input  logic [SIZE_W-1:0]              in_a_size,
    input  logic [SRC_W-1:0]               in_a_source,
    input  logic [ADDR_W-1:0]              in_a_address,
    input  logic [DATA_W/8-1:0]            in_a_mask,
    input  logic [DATA_W-1:0]              in_a_data,

    output logic                           out_a_valid,
    input  logic                           out_a_ready,
    output logic [OPCODE_W-1:0]            out_a_opcode,
    output logic [A_PARAM_W-1:0]           out_a_param,
    output logic [SIZE_W-1:0]              out_a_size,
    output logic [SRC_W-1:0]               out_a_source,
    output logic [ADDR_W-1:0]              out_a_address,
    output logic [DATA_W/8-1:0]            out_a_mask,
    output logic [DATA_W-1:0]              out_a_data,

    input  logic                           in_d_valid,
    output logic                           in_d_ready,
    input  logic [OPCODE_W-1:0]            in_d_opcode,
    input  logic [D_PARAM_W-1:0]           in_d_param,
    input  logic [SIZE_W-1:0]              in_d_size,
    input  logic [SRC_W-1:0]               in_d_source,
    input  logic                           in_d_denied,
    input  logic                           in_d_corrupt,
    input  logic [DATA_W-1:0]              in_d_data,

    output logic                           out_d_valid,
    input  logic                           out_d_ready,
    output logic [OPCODE_W-1:0]            out_d_opcode,
    output logic [D_PARAM_W-1:0]           out_d_param,
    output logic [SIZE_W-1:0]              out_d_size,
    output logic [SRC_W-1:0]               out_d_source,
    output logic                           out_d_denied,
    output logic                           out_d_corrupt,
    output logic [DATA_W-1:0]              out_d_data,

    output logic [$clog2(A_DEPTH+1)-1:0]   a_count,
    output logic [$clog2(D_DEPTH+1)-1:0]   d_count
);

    // Beats are packed in the same field order as a_beat_t / d_beat_t, but
    // sized from this module's parameters so non-default widths still work.
    localparam int A_W = OPCODE_W + A_PARAM_W + SIZE_W + SRC_W + ADDR_W
                         + DATA_W/8 + DATA_W;
    localparam int D_W = OPCODE_W + D_PARAM_W + SIZE_W + SRC_W + 2 + DATA_W;

    logic [A_W-1:0] a_in_beat;
    logic [A_W-1:0] a_out_beat;
    logic [D_W-1:0] d_in_beat;
    logic [D_W-1:0] d_out_beat;

    assign a_in_beat = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                        in_a_address, in_a_mask, in_a_data};
    assign {out_a_opcode, out_a_param, out_a_size, out_a_source,
            out_a_address, out_a_mask, out_a_data} = a_out_beat;

    assign d_in_beat = {in_d_opcode, in_d_param, in_d_size, in_d_source,
                        in_d_denied, in_d_corrupt, in_d_data};
    assign {out_d_opcode, out_d_param, out_d_size, out_d_source,
            out_d_denied, out_d_corrupt, out_d_data} = d_out_beat;

    tl_ad_fifo #(
        .DEPTH (A_DEPTH),
        .WIDTH (A_W)
    ) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_a_valid),
        .in_ready  (in_a_ready),
        .in_data   (a_in_beat),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_data  (a_out_beat),
        .count     (a_count)
    );

    tl_ad_fifo #(
        .DEPTH (D_DEPTH),
        .WIDTH (D_W)
    ) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_d_valid),
        .in_ready  (in_d_ready),
        .in_data   (d_in_beat),
        .out_valid (out_d_valid),
        .out_ready (out_d_ready),
        .out_data  (d_out_beat),
        .count     (d_count)
    );

endmodule

// File: tb/tb_tl_ad_channel_buffer.sv
// Directed bench for tl_ad_channel_buffer (default parameters). Inputs change
// and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_tl_ad_channel_buffer;
    import tl_ad_buffer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_a_valid = 0;
    logic        in_a_ready;
    logic [2:0]  in_a_opcode = 0, in_a_param = 0, in_a_size = 0;
    logic [6:0]  in_a_source = 0;
    logic [30:0] in_a_address = 0;
    logic [7:0]  in_a_mask = 0;
    logic [63:0] in_a_data = 0;
    logic        out_a_valid;
    logic        out_a_ready = 0;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [6:0]  out_a_source;
    logic [30:0] out_a_address;
    logic [7:0]  out_a_mask;
    logic [63:0] out_a_data;

    logic        in_d_valid = 0;
    logic        in_d_ready;
    logic [2:0]  in_d_opcode = 0, in_d_size = 0;
    logic [1:0]  in_d_param = 0;
    logic [6:0]  in_d_source = 0;
    logic        in_d_denied = 0, in_d_corrupt = 0;
    logic [63:0] in_d_data = 0;
    logic        out_d_valid;
    logic        out_d_ready = 0;
    logic [2:0]  out_d_opcode, out_d_size;
    logic [1:0]  out_d_param;
    logic [6:0]  out_d_source;
    logic        out_d_denied, out_d_corrupt;
    logic [63:0] out_d_data;

    logic [1:0]  a_count, d_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_ad_channel_buffer dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
        .in_a_source(in_a_source), .in_a_address(in_a_address),
        .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_opcode(out_a_opcode), .out_a_param(out_a_param), .out_a_size(out_a_size),
        .out_a_source(out_a_source), .out_a_address(out_a_address),
        .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
        .in_d_opcode(in_d_opcode), .in_d_param(in_d_param), .in_d_size(in_d_size),
        .in_d_source(in_d_source), .in_d_denied(in_d_denied),
        .in_d_corrupt(in_d_corrupt), .in_d_data(in_d_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_opcode(out_d_opcode), .out_d_param(out_d_param), .out_d_size(out_d_size),
        .out_d_source(out_d_source), .out_d_denied(out_d_denied),
        .out_d_corrupt(out_d_corrupt), .out_d_data(out_d_data),
        .a_count(a_count), .d_count(d_count)
    );

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (in_a_ready !== 1'b1 || out_a_valid !== 1'b0 || a_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_a: ready=%b valid=%b count=%0d required 1 0 0",
                     in_a_ready, out_a_valid, a_count);
        end
        checks++;
        if (in_d_ready !== 1'b1 || out_d_valid !== 1'b0 || d_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_d: ready=%b valid=%b count=%0d required 1 0 0",
                     in_d_ready, out_d_valid, d_count);
        end
        checks++;
        if (out_a_data !== 64'd0 || out_a_address !== 31'd0 || out_d_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_bits: a_data=%h a_addr=%h d_data=%h required 0",
                     out_a_data, out_a_address, out_d_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_get_latency();
        @(negedge clock);
        in_a_valid = 1; in_a_opcode = A_GET; in_a_param = 0; in_a_size = 3'd3;
        in_a_source = 7'h12; in_a_address = 31'h4000_0000; in_a_mask = 8'hFF;
        in_a_data = 64'd0;
`ifndef TL_AD_BUFFER_FLOW_EN
        #1;
        checks++;
        if (out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL get_same_cycle: out_a_valid=%b required 0", out_a_valid);
        end
`endif
        @(negedge clock);
        in_a_valid = 0;
        checks++;
        if (out_a_valid !== 1'b1 || out_a_opcode !== 3'd4 || out_a_source !== 7'h12 ||
            out_a_address !== 31'h4000_0000 || out_a_size !== 3'd3 ||
            out_a_mask !== 8'hFF || a_count !== 2'd1) begin
            errors++;
            $display("FAIL get_next_cycle: valid=%b op=%0d src=%h addr=%h size=%0d mask=%h count=%0d required 1 4 12 40000000 3 ff 1",
                     out_a_valid, out_a_opcode, out_a_source, out_a_address,
                     out_a_size, out_a_mask, a_count);
        end
        out_a_ready = 1;
        @(negedge clock);
        out_a_ready = 0;
        checks++;
        if (out_a_valid !== 1'b0 || a_count !== 2'd0) begin
            errors++;
            $display("FAIL get_drain: valid=%b count=%0d required 0 0", out_a_valid, a_count);
        end
    endtask

    task automatic test_backpressure();
        in_a_opcode = A_PUT_FULL; in_a_mask = 8'hFF;
        out_a_ready = 0;
        in_a_valid = 1; in_a_data = 64'h11;
        @(negedge clock);
        in_a_data = 64'h22;
        @(negedge clock);
        in_a_data = 64'h33;
        checks++;
        if (in_a_ready !== 1'b0 || a_count !== 2'd2) begin
            errors++;
            $display("FAIL bp_full: in_a_ready=%b count=%0d required 0 2", in_a_ready, a_count);
        end
        @(negedge clock);
        checks++;
        if (a_count !== 2'd2 || out_a_data !== 64'h11) begin
            errors++;
            $display("FAIL bp_hold: count=%0d data=%h required 2 11", a_count, out_a_data);
        end
        out_a_ready = 1;
        @(negedge clock);
        checks++;
        if (out_a_data !== 64'h22 || a_count !== 2'd1 || in_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1: data=%h count=%0d ready=%b required 22 1 1",
                     out_a_data, a_count, in_a_ready);
        end
        @(negedge clock);
        in_a_valid = 0;
        checks++;
        if (out_a_data !== 64'h33 || a_count !== 2'd1) begin
            errors++;
            $display("FAIL bp_pop2: data=%h count=%0d required 33 1", out_a_data, a_count);
        end
        @(negedge clock);
        out_a_ready = 0;
        checks++;
        if (a_count !== 2'd0 || out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: count=%0d valid=%b required 0 0", a_count, out_a_valid);
        end
    endtask

    task automatic test_wrap();
        out_a_ready = 0;
        in_a_valid = 1; in_a_data = 64'd0;
        @(negedge clock);
        for (int i = 1; i <= 20; i++) begin
            in_a_data = 64'(i);
            out_a_ready = 1;
            checks++;
            if (out_a_data !== 64'(i - 1) || a_count !== 2'd1 || out_a_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d: data=%0d count=%0d valid=%b required %0d 1 1",
                         i, out_a_data, a_count, out_a_valid, i - 1);
            end
            @(negedge clock);
        end
        in_a_valid = 0;
        checks++;
        if (out_a_data !== 64'd20 || a_count !== 2'd1) begin
            errors++;
            $display("FAIL wrap_last: data=%0d count=%0d required 20 1", out_a_data, a_count);
        end
        @(negedge clock);
        out_a_ready = 0;
        checks++;
        if (a_count !== 2'd0) begin
            errors++;
            $display("FAIL wrap_drain: count=%0d required 0", a_count);
        end
    endtask

    task automatic test_d_channel();
        out_a_ready = 0; out_d_ready = 0;
        in_d_valid = 1; in_d_opcode = D_ACCESS_ACK_DATA; in_d_param = 2'd0;
        in_d_size = 3'd3; in_d_source = 7'h05; in_d_denied = 1; in_d_corrupt = 1;
        in_d_data = 64'hDEAD_BEEF_0000_0001;
        in_a_valid = 1; in_a_opcode = A_PUT_PARTIAL; in_a_source = 7'h33;
        in_a_address = 31'h0000_1230; in_a_mask = 8'h0F; in_a_data = 64'hAA;
        @(negedge clock);
        in_d_valid = 0; in_a_valid = 0;
        checks++;
        if (out_d_valid !== 1'b1 || out_d_opcode !== 3'd1 || out_d_param !== 2'd0 ||
            out_d_size !== 3'd3 || out_d_source !== 7'h05 || out_d_denied !== 1'b1 ||
            out_d_corrupt !== 1'b1 || out_d_data !== 64'hDEAD_BEEF_0000_0001 ||
            d_count !== 2'd1) begin
            errors++;
            $display("FAIL d_beat: valid=%b op=%0d src=%h den=%b cor=%b data=%h count=%0d required 1 1 05 1 1 deadbeef00000001 1",
                     out_d_valid, out_d_opcode, out_d_source, out_d_denied,
                     out_d_corrupt, out_d_data, d_count);
        end
        checks++;
        if (out_a_data !== 64'hAA || out_a_opcode !== 3'd1 || out_a_mask !== 8'h0F ||
            out_a_address !== 31'h0000_1230 || a_count !== 2'd1) begin
            errors++;
            $display("FAIL d_parallel_a: data=%h op=%0d mask=%h addr=%h count=%0d required aa 1 0f 1230 1",
                     out_a_data, out_a_opcode, out_a_mask, out_a_address, a_count);
        end
        out_a_ready = 1; out_d_ready = 1;
        @(negedge clock);
        out_a_ready = 0; out_d_ready = 0;
        checks++;
        if (a_count !== 2'd0 || d_count !== 2'd0) begin
            errors++;
            $display("FAIL d_drain: a_count=%0d d_count=%0d required 0 0", a_count, d_count);
        end
    endtask

    task automatic test_async_reset();
        out_a_ready = 0; out_d_ready = 0;
        in_a_valid = 1; in_a_data = 64'h1;
        in_d_valid = 1; in_d_data = 64'h9;
        @(negedge clock);
        in_d_valid = 0; in_a_data = 64'h2;
        @(negedge clock);
        in_a_valid = 0;
        checks++;
        if (a_count !== 2'd2 || d_count !== 2'd1) begin
            errors++;
            $display("FAIL rst_preload: a_count=%0d d_count=%0d required 2 1", a_count, d_count);
        end
        #2 reset = 1;
        #1;
        checks++;
        if (out_a_valid !== 1'b0 || out_d_valid !== 1'b0 || a_count !== 2'd0 ||
            d_count !== 2'd0 || in_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: a_valid=%b d_valid=%b a_count=%0d d_count=%0d a_ready=%b required 0 0 0 0 1",
                     out_a_valid, out_d_valid, a_count, d_count, in_a_ready);
        end
        @(negedge clock);
        reset = 0;
        in_a_valid = 1; in_a_data = 64'h77;
        @(negedge clock);
        in_a_valid = 0;
        checks++;
        if (out_a_data !== 64'h77 || a_count !== 2'd1) begin
            errors++;
            $display("FAIL rst_next_beat: data=%h count=%0d required 77 1", out_a_data, a_count);
        end
        out_a_ready = 1;
        @(negedge clock);
        out_a_ready = 0;
        checks++;
        if (out_a_valid !== 1'b0 || a_count !== 2'd0) begin
            errors++;
            $display("FAIL rst_alone: valid=%b count=%0d required 0 0", out_a_valid, a_count);
        end
    endtask

`ifdef TL_AD_BUFFER_FLOW_EN
    task automatic test_flow();
        in_a_valid = 1; in_a_data = 64'h5A; out_a_ready = 1;
        #1;
        checks++;
        if (out_a_valid !== 1'b1 || out_a_data !== 64'h5A) begin
            errors++;
            $display("FAIL flow_same_cycle: valid=%b data=%h required 1 5a", out_a_valid, out_a_data);
        end
        @(negedge clock);
        in_a_valid = 0; out_a_ready = 0;
        #1;
        checks++;
        if (a_count !== 2'd0 || out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL flow_not_stored: count=%0d valid=%b required 0 0", a_count, out_a_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_get_latency();
        test_backpressure();
        test_wrap();
        test_d_channel();
        test_async_reset();
`ifdef TL_AD_BUFFER_FLOW_EN
        test_flow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_ad_channel_buffer.md
Name: tl_ad_channel_buffer

Overview:
- Registered TileLink A/D channel buffer.
- Sits directly upstream of the TL channel pass-through port adapter: the master side enters here, and the buffered A/D signals drive the adapter's inputs.
- Breaks combinational valid/ready paths between the core-side crossbar and the AXI4 bridge port using two independent FIFOs: A (request, master→slave) and D (response, slave→master).

Parameters:
- A_DEPTH, 2, A-channel FIFO entries (1..8, need not be a power of 2)
- D_DEPTH, 2, D-channel FIFO entries (1..8)
- SRC_W, 7, source-ID width
- ADDR_W, 31, address width
- DATA_W, 64, data width; mask width = DATA_W/8

Ports:
- clock  input  1  sole clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_a_valid / in_a_ready  input / output  1 / 1  upstream A handshake
- in_a_opcode, in_a_param, in_a_size  input  3 each  A fields
- in_a_source  input  SRC_W;  in_a_address  input  ADDR_W
- in_a_mask  input  DATA_W/8;  in_a_data  input  DATA_W
- out_a_valid / out_a_ready  output / input  1 / 1  downstream A handshake
- out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data  output  same widths as in_a_*
- in_d_valid / in_d_ready  input / output  1 / 1  downstream-side D handshake
- in_d_opcode 3, in_d_param 2, in_d_size 3, in_d_source SRC_W, in_d_denied 1, in_d_corrupt 1, in_d_data DATA_W  input
- out_d_valid / out_d_ready  output / input  1 / 1  upstream-side D handshake
- out_d_* fields  output  same widths as in_d_*
- a_count  output  clog2(A_DEPTH+1)  A occupancy
- d_count  output  clog2(D_DEPTH+1)  D occupancy

Behaviour:
- Each channel is an identical circular FIFO. Enqueue on in_valid&in_ready; dequeue on out_valid&out_ready.
- in_ready = (count != DEPTH). It depends on registered count only, never on out_ready: no same-cycle pass-through when full.
- out_valid = (count != 0). out_* bits = storage[rd_ptr], muxed from registers with no combinational path from in_*.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 (feature disabled).
- Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- count update: +1 on enq only, -1 on deq only, unchanged on both.
- Simultaneous enq+deq:
  - when count==0: enq only, since out_valid=0.
  - when count==DEPTH: deq only, since in_ready=0.
  - otherwise: both occur.
- TL payload is never modified, reordered or dropped. FIFO order is strict per channel; A and D are fully independent.
- Protocol: once out_valid is high it stays high with stable bits until fired. Guaranteed structurally.
- Reset (asynchronous, any cycle including mid-burst):
  - pointers = 0, count = 0, storage = 0
  - out_valid = 0, out_* bits = 0, in_ready = 1, a_count = d_count = 0
  - In-flight entries are discarded.
- Deassertion of reset is expected synchronous to clock; the first enqueue is legal in the first cycle after deassertion.

Optional Feature:
- Macro: TL_AD_BUFFER_FLOW_EN.
- Defined: when count==0 and in_valid==1, out_valid=1 with out_* = in_* combinationally.
  - If out_ready is also 1, the beat passes without being stored; count stays 0.
  - If out_ready is 0, the beat is enqueued normally.
  - in_ready is unchanged (still !full).
- Undefined: strict registered behaviour as above; minimum latency 1 cycle.

Decomposition:
- Package tl_ad_buffer_pkg holds:
  - localparams for field widths: OPCODE_W=3, A_PARAM_W=3, D_PARAM_W=2, SIZE_W=3
  - A opcodes: PutFull=0, PutPartial=1, Get=4
  - D opcodes: AccessAck=0, AccessAckData=1
  - a_beat_t / d_beat_t packed structs
- One sub-module, tl_ad_fifo: generic DEPTH×WIDTH FIFO with the handshake, count and optional flow logic. Instantiated twice on packed A and D beats.

Test Plan:
- After reset, in_a_ready=1 and out_a_valid=0. Enqueue Get (opcode 4, address 0x4000_0000, source 0x12) in cycle 0 → out_a_valid=1 in cycle 1 with identical fields and a_count=1.
- out_a_ready=0, push 3 beats with data 0x11, 0x22, 0x33 → first two accepted, in_a_ready=0 with a_count=2, third held. Release out_a_ready → pops 0x11, 0x22, 0x33 in order.
- a_count=1 with continuous enq+deq for 20 cycles → a_count stays 1, pointer wraps every 2 cycles, no beat lost (data sequence 1..20 checked).
- D channel: AccessAckData with denied=1, corrupt=1, data 0xDEAD_BEEF_0000_0001 → reproduced bit-exact one cycle later; A traffic in parallel is unaffected.
- Assert reset while a_count=2 and d_count=1 → out_a_valid and out_d_valid drop immediately (asynchronously), counts are 0, and the next beat after release emerges alone.
- With TL_AD_BUFFER_FLOW_EN, empty FIFO, in_a_valid=1 and out_a_ready=1 → out_a_valid=1 in the same cycle and a_count remains 0.
